// File: rtl/game_pkg.sv
// Shared types for the grid game: cell codes, results, FSM states and the
// per-direction step table used by the line scanner.
package game_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    RES_PLAY   = 2'b00,
    RES_P1_WIN = 2'b01,
    RES_P2_WIN = 2'b10,
    RES_TIE    = 2'b11
  } result_t;

  // Encoding doubles as the LED state code.
  typedef enum logic [2:0] {
    ST_PLAY     = 3'd0,
    ST_PLACE    = 3'd1,
    ST_SCAN_FWD = 3'd2,
    ST_SCAN_BWD = 3'd3,
    ST_NEXT_DIR = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } step_t;

  // Forward step for each scan direction; the backward scan negates it.
  function automatic step_t dir_step(input logic [1:0] d);
    step_t s;
    case (d)
      2'd0:    begin s.dr = 2'sd0; s.dc = 2'sd1;  end  // horizontal
      2'd1:    begin s.dr = 2'sd1; s.dc = 2'sd0;  end  // vertical
      2'd2:    begin s.dr = 2'sd1; s.dc = 2'sd1;  end  // diagonal
      2'd3:    begin s.dr = 2'sd1; s.dc = -2'sd1; end  // anti-diagonal
      default: begin s.dr = 2'sd0; s.dc = 2'sd0;  end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cell_walker.sv
// Combinational neighbour generator: one step from (row, col) along direction
// d, forward or backward, with an in-bounds flag so the scan never wraps.
module cell_walker
  import game_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [1:0]    d,
  input  logic          sign,
  output logic [CW-1:0] next_row,
  output logic [CW-1:0] next_col,
  output logic          in_bounds
);

  localparam int EW = CW + 2;

  step_t                step_s;
  logic signed [1:0]    dr_s;
  logic signed [1:0]    dc_s;
  logic signed [EW-1:0] r_ext_s;
  logic signed [EW-1:0] c_ext_s;

  // Signed coordinate arithmetic so stepping off either edge is detectable.
  always_comb begin
    step_s    = dir_step(d);
    dr_s      = sign ? -step_s.dr : step_s.dr;
    dc_s      = sign ? -step_s.dc : step_s.dc;
    r_ext_s   = $signed({2'b00, row}) + EW'(dr_s);
    c_ext_s   = $signed({2'b00, col}) + EW'(dc_s);
    next_row  = r_ext_s[CW-1:0];
    next_col  = c_ext_s[CW-1:0];
    in_bounds = !r_ext_s[EW-1] && !c_ext_s[EW-1] &&
                (r_ext_s < EW'(N)) && (c_ext_s < EW'(N));
  end

endmodule

// File: rtl/grid_game_fsm.sv
// N x N K-in-a-row game controller: validates moves, places them, scans the
// four lines through the placed cell one cell per cycle, and keeps scores.
module grid_game_fsm
  import game_pkg::*;
#(
  parameter int N            = 3,
  parameter int K            = 3,
  parameter int WIN_MAX      = 9,
  parameter int LOSER_STARTS = 0,
  localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int SW = $clog2(WIN_MAX + 1)
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst,
  input  logic              move_req,
  input  logic [CW-1:0]     move_row,
  input  logic [CW-1:0]     move_col,
  input  logic              new_game,
  output logic [2*N*N-1:0]  board,
  output logic              player,
  output logic              busy,
  output logic              move_ack,
  output logic              move_err,
  output logic [1:0]        result,
  output logic [SW-1:0]     score1,
  output logic [SW-1:0]     score2,
  output logic [2:0]        state_code
);

  localparam int NN  = N * N;
  localparam int MCW = $clog2(NN + 1);
  localparam int RW  = $clog2(K + 1);

  state_t            state_r, state_nxt;
  result_t           result_r, result_nxt;
  logic [2*NN-1:0]   board_r, board_nxt;
  logic              player_r, player_nxt;
  logic              loser_r, loser_nxt;
  logic [SW-1:0]     score1_r, score1_nxt, score2_r, score2_nxt;
  logic [MCW-1:0]    cnt_r, cnt_nxt;
  logic [1:0]        d_r, d_nxt;
  logic [RW-1:0]     run_r, run_nxt;
  logic [CW-1:0]     pos_row_r, pos_row_nxt, pos_col_r, pos_col_nxt;
  logic [CW-1:0]     org_row_r, org_row_nxt, org_col_r, org_col_nxt;
  logic              ack_r, ack_nxt, err_r, err_nxt, busy_r, busy_nxt;

  logic [CW-1:0]     step_row_s, step_col_s;
  logic              step_ok_s, step_match_s, move_in_range_s;
  logic [1:0]        mover_code_s;
  int                place_idx_s;

  // Cell read that returns empty for any coordinate outside the board.
  function automatic logic [1:0] read_cell(input logic [2*NN-1:0] b,
                                           input logic [CW-1:0] r,
                                           input logic [CW-1:0] c);
    logic [1:0] v;
    int         i;
    v = 2'b00;
    i = int'(r) * N + int'(c);
    if ((int'(r) < N) && (int'(c) < N)) v = b[2*i +: 2];
    else v = 2'b00;
    return v;
  endfunction

  cell_walker #(.N(N), .CW(CW)) u_walker (
    .row       (pos_row_r),
    .col       (pos_col_r),
    .d         (d_r),
    .sign      (state_r == ST_SCAN_BWD),
    .next_row  (step_row_s),
    .next_col  (step_col_s),
    .in_bounds (step_ok_s)
  );

  // Next-state, datapath and pulse logic; new_game overrides every state.
  always_comb begin
    state_nxt   = state_r;   result_nxt  = result_r;  board_nxt   = board_r;
    player_nxt  = player_r;  loser_nxt   = loser_r;   score1_nxt  = score1_r;
    score2_nxt  = score2_r;  cnt_nxt     = cnt_r;     d_nxt       = d_r;
    run_nxt     = run_r;     pos_row_nxt = pos_row_r; pos_col_nxt = pos_col_r;
    org_row_nxt = org_row_r; org_col_nxt = org_col_r;
    ack_nxt     = 1'b0;      err_nxt     = 1'b0;
    mover_code_s    = player_r ? CELL_P2 : CELL_P1;
    step_match_s    = step_ok_s && (read_cell(board_r, step_row_s, step_col_s) == mover_code_s);
    move_in_range_s = (int'(move_row) < N) && (int'(move_col) < N);
    place_idx_s     = int'(org_row_r) * N + int'(org_col_r);

    if (new_game) begin
      board_nxt  = '0;
      cnt_nxt    = '0;
      result_nxt = RES_PLAY;
      state_nxt  = ST_PLAY;
      player_nxt = (LOSER_STARTS != 0) ? loser_r : 1'b0;
      if ((score1_r == SW'(WIN_MAX)) || (score2_r == SW'(WIN_MAX))) begin
        score1_nxt = '0;
        score2_nxt = '0;
      end else begin
        score1_nxt = score1_r;
        score2_nxt = score2_r;
      end
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (move_req) begin
            if (move_in_range_s && (read_cell(board_r, move_row, move_col) == CELL_EMPTY)) begin
              org_row_nxt = move_row;
              org_col_nxt = move_col;
              state_nxt   = ST_PLACE;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            state_nxt = ST_PLAY;
          end
        end
        ST_PLACE: begin
          if (place_idx_s < NN) board_nxt[2*place_idx_s +: 2] = mover_code_s;
          else board_nxt = board_r;
          ack_nxt     = 1'b1;
          cnt_nxt     = cnt_r + MCW'(1);
          d_nxt       = 2'd0;
          run_nxt     = RW'(1);
          pos_row_nxt = org_row_r;
          pos_col_nxt = org_col_r;
          state_nxt   = ST_SCAN_FWD;
        end
        ST_SCAN_FWD: begin
          if (int'(run_r) >= K) begin
            state_nxt = ST_NEXT_DIR;
          end else if (step_match_s) begin
            run_nxt     = run_r + RW'(1);
            pos_row_nxt = step_row_s;
            pos_col_nxt = step_col_s;
          end else begin
            pos_row_nxt = org_row_r;
            pos_col_nxt = org_col_r;
            state_nxt   = ST_SCAN_BWD;
          end
        end
        ST_SCAN_BWD: begin
          if (int'(run_r) >= K) begin
            state_nxt = ST_NEXT_DIR;
          end else if (step_match_s) begin
            run_nxt     = run_r + RW'(1);
            pos_row_nxt = step_row_s;
            pos_col_nxt = step_col_s;
          end else begin
            state_nxt = ST_NEXT_DIR;
          end
        end
        ST_NEXT_DIR: begin
          if (int'(run_r) >= K) begin
            state_nxt  = ST_DONE;
            result_nxt = player_r ? RES_P2_WIN : RES_P1_WIN;
            loser_nxt  = ~player_r;
            if (player_r) score2_nxt = score2_r + SW'(1);
            else score1_nxt = score1_r + SW'(1);
          end else if (d_r == 2'd3) begin
            if (int'(cnt_r) == NN) begin
              state_nxt  = ST_DONE;
              result_nxt = RES_TIE;
              loser_nxt  = 1'b0;
            end else begin
              player_nxt = ~player_r;
              state_nxt  = ST_PLAY;
            end
          end else begin
            d_nxt       = d_r + 2'd1;
            run_nxt     = RW'(1);
            pos_row_nxt = org_row_r;
            pos_col_nxt = org_col_r;
            state_nxt   = ST_SCAN_FWD;
          end
        end
        ST_DONE: begin
          if (move_req) err_nxt = 1'b1;
          else err_nxt = 1'b0;
        end
        default: state_nxt = ST_PLAY;
      endcase
    end
    busy_nxt = !((state_nxt == ST_PLAY) || (state_nxt == ST_DONE));
  end

  // State and datapath registers; reset gives an empty board with P1 to move.
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      state_r   <= ST_PLAY;  result_r  <= RES_PLAY; board_r   <= '0;
      player_r  <= 1'b0;     loser_r   <= 1'b0;     score1_r  <= '0;
      score2_r  <= '0;       cnt_r     <= '0;       d_r       <= 2'd0;
      run_r     <= '0;       pos_row_r <= '0;       pos_col_r <= '0;
      org_row_r <= '0;       org_col_r <= '0;       ack_r     <= 1'b0;
      err_r     <= 1'b0;     busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;   result_r  <= result_nxt;  board_r   <= board_nxt;
      player_r  <= player_nxt;  loser_r   <= loser_nxt;   score1_r  <= score1_nxt;
      score2_r  <= score2_nxt;  cnt_r     <= cnt_nxt;     d_r       <= d_nxt;
      run_r     <= run_nxt;     pos_row_r <= pos_row_nxt; pos_col_r <= pos_col_nxt;
      org_row_r <= org_row_nxt; org_col_r <= org_col_nxt; ack_r     <= ack_nxt;
      err_r     <= err_nxt;     busy_r    <= busy_nxt;
    end
  end

  assign board      = board_r;
  assign player     = player_r;
  assign busy       = busy_r;
  assign move_ack   = ack_r;
  assign move_err   = err_r;
  assign result     = result_r;
  assign score1     = score1_r;
  assign score2     = score2_r;
  assign state_code = state_r;

endmodule

// File: tb/tb_grid_game_fsm.sv
// Bench for grid_game_fsm: two instances (3x3/K3 with loser-starts and a
// score limit of 2, 5x5/K4 with P1 always opening), directed games followed by
// random play, all checked against a cell-array model of the game rules.
module tb_grid_game_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mreq, ngame, sel;
  logic [2:0] mrow, mcol;

  logic [17:0] a_board;  logic a_player, a_busy, a_ack, a_err;
  logic [1:0]  a_result, a_s1, a_s2; logic [2:0] a_state;
  logic [49:0] b_board;  logic b_player, b_busy, b_ack, b_err;
  logic [1:0]  b_result; logic [3:0] b_s1, b_s2; logic [2:0] b_state;

  grid_game_fsm #(.N(3), .K(3), .WIN_MAX(2), .LOSER_STARTS(1)) dut_a (
    .MAX10_CLK1_50(clk), .rst(rst), .move_req(mreq & ~sel),
    .move_row(mrow[1:0]), .move_col(mcol[1:0]), .new_game(ngame & ~sel),
    .board(a_board), .player(a_player), .busy(a_busy), .move_ack(a_ack),
    .move_err(a_err), .result(a_result), .score1(a_s1), .score2(a_s2),
    .state_code(a_state));

  grid_game_fsm #(.N(5), .K(4), .WIN_MAX(9), .LOSER_STARTS(0)) dut_b (
    .MAX10_CLK1_50(clk), .rst(rst), .move_req(mreq & sel),
    .move_row(mrow), .move_col(mcol), .new_game(ngame & sel),
    .board(b_board), .player(b_player), .busy(b_busy), .move_ack(b_ack),
    .move_err(b_err), .result(b_result), .score1(b_s1), .score2(b_s2),
    .state_code(b_state));

  logic [127:0] o_board; logic o_player, o_busy, o_ack, o_err;
  logic [1:0] o_result; logic [7:0] o_s1, o_s2; logic [2:0] o_state;

  // Route the selected instance's outputs to one observation bus.
  always_comb begin
    if (sel) begin
      o_board = 128'(b_board); o_player = b_player; o_busy = b_busy; o_ack = b_ack;
      o_err = b_err; o_result = b_result; o_s1 = 8'(b_s1); o_s2 = 8'(b_s2); o_state = b_state;
    end else begin
      o_board = 128'(a_board); o_player = a_player; o_busy = a_busy; o_ack = a_ack;
      o_err = a_err; o_result = a_result; o_s1 = 8'(a_s1); o_s2 = 8'(a_s2); o_state = a_state;
    end
  end

  // Game model: cell array (0 empty, 1 P1, 2 P2), side to move, result, scores.
  int mN, mK, mW, mLS;
  int mb [8][8];
  int mp, mres, ms1, ms2, ml, mcnt;
  int n_asserts = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_win(input int r, input int c, input int code);
    int dr_t [4];
    int dc_t [4];
    int n, rr, cc;
    dr_t = '{0, 1, 1, 1};
    dc_t = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        rr = r + s * dr_t[d];
        cc = c + s * dc_t[d];
        while (rr >= 0 && rr < mN && cc >= 0 && cc < mN && mb[rr][cc] == code) begin
          n++;
          rr += s * dr_t[d];
          cc += s * dc_t[d];
        end
      end
      if (n >= mK) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[r][c] = 0;
    mcnt = 0;
    mres = 0;
  endtask

  task automatic model_reset();
    model_clear_board();
    mp = 0; ms1 = 0; ms2 = 0; ml = 0;
  endtask

  task automatic check_all(input string tag);
    logic [127:0] eb;
    eb = '0;
    for (int i = 0; i < mN * mN; i++) eb[2*i +: 2] = 2'(mb[i / mN][i % mN]);
    chk({tag, ".board"},  o_board,  eb);
    chk({tag, ".player"}, o_player, 128'(mp));
    chk({tag, ".result"}, o_result, 128'(mres));
    chk({tag, ".score1"}, o_s1,     128'(ms1));
    chk({tag, ".score2"}, o_s2,     128'(ms2));
    chk({tag, ".state"},  o_state,  (mres != 0) ? 128'd5 : 128'd0);
    chk({tag, ".busy"},   o_busy,   128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    chk("reset.ack", o_ack, 0);
    chk("reset.err", o_err, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_newgame(input bit with_move);
    @(negedge clk);
    ngame = 1'b1;
    if (with_move) begin mreq = 1'b1; mrow = 3'd0; mcol = 3'd0; end
    @(negedge clk);
    ngame = 1'b0; mreq = 1'b0;
    model_clear_board();
    if (ms1 == mW || ms2 == mW) begin ms1 = 0; ms2 = 0; end
    mp = (mLS != 0) ? ml : 0;
    chk("newgame.ack", o_ack, 0);
    chk("newgame.err", o_err, 0);
    check_all("newgame");
  endtask

  task automatic do_move(input int r, input int c, input bit poke);
    int acks, errs, cyc, lim, code;
    bit legal;
    lim   = 1 + 4 * (2 * (mK - 1) + 1);
    legal = (mres == 0) && r < mN && c < mN && mb[r][c] == 0;
    @(negedge clk);
    mrow = 3'(r); mcol = 3'(c); mreq = 1'b1;
    @(negedge clk);
    mreq = 1'b0;
    if (!legal) begin
      chk("reject.err", o_err, 1);
      chk("reject.ack", o_ack, 0);
      check_all("reject");
    end else begin
      acks = 0; errs = 0; cyc = 0;
      while (o_busy === 1'b1 && cyc < lim + 4) begin
        acks += int'(o_ack);
        errs += int'(o_err);
        if (poke && cyc == 0) begin
          mrow = 3'((r + 1) % mN); mcol = 3'(c); mreq = 1'b1;
        end else begin
          mreq = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
      mreq = 1'b0;
      acks += int'(o_ack);
      errs += int'(o_err);
      chk("move.latency", (cyc >= 3 && cyc <= lim), 1);
      chk("move.acks", acks, 1);
      chk("move.errs", errs, 0);
      code = mp + 1;
      mb[r][c] = code;
      mcnt++;
      if (model_win(r, c, code)) begin
        mres = code;
        if (code == 1) ms1++; else ms2++;
        ml = (code == 1) ? 1 : 0;
      end else if (mcnt == mN * mN) begin
        mres = 3;
        ml = 0;
      end else begin
        mp = 1 - mp;
      end
      check_all("move");
    end
  endtask

  task automatic play_cells(input int cells [], input int count);
    for (int i = 0; i < count; i++) do_move(cells[i] / mN, cells[i] % mN, 1'b0);
  endtask

  task automatic random_phase(input int iters);
    for (int i = 0; i < iters; i++) begin
      if (mres != 0) begin
        if ($urandom_range(0, 4) != 0) do_newgame($urandom_range(0, 1) == 1);
        else do_move($urandom_range(0, mN - 1), $urandom_range(0, mN - 1), 1'b0);
      end else if ($urandom_range(0, 29) == 0) begin
        do_newgame($urandom_range(0, 1) == 1);
      end else begin
        do_move($urandom_range(0, mN), $urandom_range(0, mN), $urandom_range(0, 9) == 0);
      end
    end
  endtask

  // Watchdog: a hung run still reports before stopping.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tie_seq [] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int win_seq [] = '{0, 3, 1, 4, 2};
    int win2_seq [] = '{0, 6, 1, 7, 2};
    int anti_seq [] = '{0, 4, 1, 8, 2, 12, 20, 16};

    rst = 1'b1; mreq = 1'b0; ngame = 1'b0; sel = 1'b0; mrow = 3'd0; mcol = 3'd0;
    mN = 3; mK = 3; mW = 2; mLS = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    rst = 1'b0;

    // Full board with no line: tie, scores untouched; move in DONE rejected.
    play_cells(tie_seq, 9);
    chk("tie.result", o_result, 2'b11);
    chk("tie.score1", o_s1, 0);
    do_move(0, 0, 1'b0);

    // P1 top-row win; after a tie P1 opens again.
    do_newgame(1'b0);
    chk("after_tie.player", o_player, 0);
    play_cells(win_seq, 5);
    chk("p1win.result", o_result, 2'b01);
    chk("p1win.score1", o_s1, 1);
    chk("p1win.state", o_state, 3'd5);

    // Loser (P2) opens; occupied cell and row 3 both rejected.
    do_newgame(1'b0);
    chk("loser_starts.player", o_player, 1);
    do_move(1, 1, 1'b0);
    do_move(1, 1, 1'b0);
    do_move(3, 0, 1'b0);
    chk("rejects.player", o_player, 0);

    // Second P1 win reaches the score limit; new_game clears both scores.
    play_cells(win2_seq, 5);
    chk("p1win2.score1", o_s1, 2);
    do_newgame(1'b0);
    chk("limit.score1", o_s1, 0);
    chk("limit.score2", o_s2, 0);
    chk("limit.player", o_player, 1);

    // new_game in the middle of a scan.
    @(negedge clk); mrow = 3'd0; mcol = 3'd0; mreq = 1'b1;
    @(negedge clk); mreq = 1'b0;
    @(negedge clk);
    chk("midscan.state", o_state, 3'd2);
    do_newgame(1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("midscan.no_ack", o_ack, 0);
    end

    // new_game and move_req together: move dropped; then a poked move.
    do_newgame(1'b1);
    do_move(2, 2, 1'b1);

    // Reset in the middle of a scan.
    @(negedge clk); mrow = 3'd1; mcol = 3'd1; mreq = 1'b1;
    @(negedge clk); mreq = 1'b0;
    do_reset();
    repeat (2) begin
      @(negedge clk);
      chk("after_rst.no_ack", o_ack, 0);
    end

    random_phase(200);

    // 5x5, K=4: P2 anti-diagonal win.
    sel = 1'b1;
    mN = 5; mK = 4; mW = 9; mLS = 0;
    do_reset();
    play_cells(anti_seq, 8);
    chk("anti.result", o_result, 2'b10);
    chk("anti.score2", o_s2, 1);
    do_newgame(1'b0);
    chk("b_newgame.player", o_player, 0);

    random_phase(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_game_fsm.md
GRID_GAME_FSM -- requirements
Module: grid_game_fsm

Interface
REQ-001 Parameter N, default 3, board side length; legal range 3..8.
REQ-002 Parameter K, default 3, win run length; legal range 3..N.
REQ-003 Parameter WIN_MAX, default 9, score limit that triggers a score clear.
REQ-004 Parameter LOSER_STARTS, default 0; 0 = P1 always opens, 1 = loser of the previous game opens (P1 after a tie).
REQ-005 Derived width CW = max(1, clog2(N)); SW = clog2(WIN_MAX+1).
REQ-006 MAX10_CLK1_50  in  1  the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 move_req  in  1  single-cycle move strobe.
REQ-009 move_row, move_col  in  CW each  target cell.
REQ-010 new_game  in  1  single-cycle strobe that clears the board and starts a game.
REQ-011 board  out  2*N*N  cell i = r*N+c at bits [2i+1:2i]; codes: 00 empty, 01 P1, 10 P2, 11 never driven.
REQ-012 player  out  1  side to move; 0 = P1, 1 = P2.
REQ-013 busy  out  1  high while placing or scanning.
REQ-014 move_ack, move_err  out  1 each  single-cycle accept and reject pulses.
REQ-015 result  out  2  00 in play, 01 P1 win, 10 P2 win, 11 tie.
REQ-016 score1, score2  out  SW each  win counts.
REQ-017 state_code  out  3  current FSM state for LED display.

Function
REQ-018 States: PLAY, PLACE, SCAN_FWD, SCAN_BWD, NEXT_DIR, DONE.
REQ-019 PLAY plus move_req: reject if row>=N, col>=N or cell occupied, with move_err high the next cycle and the state staying PLAY; otherwise go to PLACE.
REQ-020 PLACE, 1 cycle: write the player code to the cell, pulse move_ack, increment move count, direction d=0, run=1.
REQ-021 Directions are d0 horizontal, d1 vertical, d2 diagonal (+1,+1), d3 anti-diagonal (+1,-1).
REQ-022 SCAN_FWD and SCAN_BWD step one cell per cycle from the placed cell; each step increments run on a matching code and ends on a mismatch, a board edge or run==K.
REQ-023 NEXT_DIR: if run>=K, go to DONE with the mover's win; else if d==3 and move count==N*N, go to DONE with result 11; else if d==3, toggle player and go to PLAY; otherwise d+1, run=1, go to SCAN_FWD.
REQ-024 Worst-case latency from accepted move_req to PLAY or DONE is 1 + 4*(2*(K-1)+1) cycles.
REQ-025 A win detected on the final empty cell reports the win, not a tie.
REQ-026 Entering DONE with a win increments score1 or score2 by exactly 1; a tie changes neither score.
REQ-027 move_req while busy is ignored, with neither move_ack nor move_err.
REQ-028 move_req in DONE pulses move_err.
REQ-029 new_game from any state, including mid-scan, clears the board, move count and result and enters PLAY the next cycle.
REQ-030 On new_game, the opening player follows LOSER_STARTS.
REQ-031 On new_game, if score1 or score2 equals WIN_MAX, both scores clear to 0.
REQ-032 new_game and move_req in the same cycle: new_game wins and the move is dropped silently.
REQ-033 The scan never addresses outside the board; edge cells terminate the run and do not wrap.

Reset
REQ-034 rst asynchronously forces: board all 00, player 0, state PLAY, result 00, scores 0, move count 0, move_ack/move_err/busy 0, last loser = P1.
REQ-035 Deassertion of rst is synchronised to MAX10_CLK1_50 by the instantiating top level.

Structure
REQ-036 Shared package game_pkg holds the cell-code enum, result enum, state enum with state_code encoding, and direction step table.
REQ-037 One sub-module, cell_walker: a combinational next-coordinate and in-bounds check for (row, col, d, sign), instantiated once.
REQ-038 Board storage is a flat register; no RAM inference.

Verification
REQ-039 N=3,K=3: P1 (0,0),(0,1),(0,2) with P2 (1,0),(1,1) -> result 01, score1=1, move_ack x5, state DONE.
REQ-040 N=3: move to occupied (1,1), then row=3 -> two move_err pulses, board unchanged, player unchanged.
REQ-041 N=3: fill P1 0,2,3,7,8 and P2 1,4,5,6 in alternation without a line -> result 11, scores unchanged.
REQ-042 N=5,K=4: P2 anti-diagonal (0,4),(1,3),(2,2),(3,1) -> result 10 within 1+4*7 cycles of the last ack.
REQ-043 WIN_MAX=2: two P1 wins, then new_game -> score1=0, score2=0; LOSER_STARTS=1 -> player=1 after a P1 win.
REQ-044 new_game asserted during SCAN_FWD, then rst mid-game -> board all 00, state PLAY after each, no stray ack.
